// File: rtl/fp8_quant_packer.sv
// Streaming FP32 -> FP8 quantizer packing LANES bytes per word; one-cycle registered output,
// input stalls (in_ready low) whenever a packed word is held and out_ready is low.

// FP32 -> FP8 (bias 2^(E-1)-1), round-to-nearest-even, saturating to max finite; combinational.
module Float8_pack #(
   parameter int E = 4,
   parameter int M = 3
) (
   input  logic [31:0] fp32_i,
   output logic [7:0]  fp8_o,
   output logic        sat_o
);
   localparam int BIAS = (1 << (E - 1)) - 1;
   localparam int EMAX = (1 << E) - 1;
   localparam logic signed [9:0] BIAS10  = 10'(BIAS);
   localparam logic signed [9:0] EMAX10  = 10'(EMAX);
   localparam logic [E+M:0]      MAXCODE = (E + M + 1)'((1 << (E + M)) - 2);

   logic                w_sign;
   logic [7:0]          w_exp;
   logic [22:0]         w_frac;
   logic [23:0]         w_sig;
   logic signed [9:0]   w_te;
   logic [4:0]          w_sh;
   logic [47:0]         w_ext;
   logic                w_lsb, w_g, w_st;
   logic [E+M:0]        w_code;

   assign w_sign = fp32_i[31];
   assign w_exp  = fp32_i[30:23];
   assign w_frac = fp32_i[22:0];
   assign w_sig  = {1'b1, w_frac};
   assign w_te   = $signed({2'b00, w_exp}) - 10'sd127 + BIAS10;

   always_comb begin
      w_sh   = '0;
      w_ext  = '0;
      w_lsb  = 1'b0;
      w_g    = 1'b0;
      w_st   = 1'b0;
      w_code = '0;
      sat_o  = 1'b0;
      fp8_o  = '0;
      if (w_te >= 10'sd1) begin
         w_lsb  = w_frac[23-M];
         w_g    = w_frac[22-M];
         w_st   = |w_frac[21-M:0];
         w_code = {1'b0, w_te[E-1:0], w_frac[22 -: M]} + (E + M + 1)'(w_g & (w_st | w_lsb));
      end else begin
         // Subnormal target: denormalise the full significand, rounding carry may reach exponent 1.
         w_sh   = (w_te < -10'sd30) ? 5'd31 : 5'(10'sd1 - w_te);
         w_ext  = {w_sig, 24'h0} >> w_sh;
         w_lsb  = w_ext[47-M];
         w_g    = w_ext[46-M];
         w_st   = |w_ext[45-M:0];
         w_code = (E + M + 1)'(w_ext[47 -: M+1]) + (E + M + 1)'(w_g & (w_st | w_lsb));
      end

      if (w_exp == 8'hFF) begin
         if (|w_frac) begin
            fp8_o = {w_sign, {(E + M){1'b1}}};
         end else begin
            fp8_o = {w_sign, MAXCODE[E+M-1:0]};
            sat_o = 1'b1;
         end
      end else if ((w_te > EMAX10) || (w_code > MAXCODE)) begin
         fp8_o = {w_sign, MAXCODE[E+M-1:0]};
         sat_o = 1'b1;
      end else begin
         fp8_o = {w_sign, w_code[E+M-1:0]};
      end
   end
endmodule

// Packer: lane 0 is the first element; in_last or a full stage closes the word.
module fp8_quant_packer #(
   parameter int E     = 4,
   parameter int M     = 3,
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic [LANES-1:0]     out_keep,
   output logic                 out_last,
   output logic [15:0]          sat_count,
   input  logic                 clear_sat
);
   localparam int IW = $clog2(LANES);
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   logic [7:0]          w_byte;
   logic                w_sat;
   logic                w_acc;
   logic                w_complete;
   logic [8*LANES-1:0]  w_merge_data;
   logic [LANES-1:0]    w_merge_keep;

   logic [IW-1:0]       r_idx;
   logic [8*LANES-1:0]  r_stage;
   logic [LANES-1:0]    r_skeep;
   logic                r_out_valid;
   logic [8*LANES-1:0]  r_out_data;
   logic [LANES-1:0]    r_out_keep;
   logic                r_out_last;
   logic [15:0]         r_sat_count;

   Float8_pack #(.E(E), .M(M)) u_pack (
      .fp32_i (in_data),
      .fp8_o  (w_byte),
      .sat_o  (w_sat)
   );

   assign in_ready   = !r_out_valid || out_ready;
   assign w_acc      = in_valid && in_ready;
   assign w_complete = w_acc && ((r_idx == LAST_IDX) || in_last);

   always_comb begin
      w_merge_data              = r_stage;
      w_merge_keep              = r_skeep;
      w_merge_data[8*r_idx +: 8] = w_byte;
      w_merge_keep[r_idx]       = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_stage     <= '0;
         r_skeep     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_complete) begin
            r_out_data  <= w_merge_data;
            r_out_keep  <= w_merge_keep;
            r_out_last  <= in_last;
            r_out_valid <= 1'b1;
            r_stage     <= '0;
            r_skeep     <= '0;
            r_idx       <= '0;
         end else begin
            if (r_out_valid && out_ready) begin
               r_out_valid <= 1'b0;
            end
            if (w_acc) begin
               r_stage <= w_merge_data;
               r_skeep <= w_merge_keep;
               r_idx   <= r_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_count <= '0;
      end else if (clear_sat) begin
         r_sat_count <= '0;
      end else if (w_acc && w_sat && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_keep  = r_out_keep;
   assign out_last  = r_out_last;
   assign sat_count = r_sat_count;
endmodule

// File: tb/tb_fp8_quant_packer.sv
// Directed bench for fp8_quant_packer with hand-computed E4M3 bytes and packed words.
module tb_fp8_quant_packer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic [15:0] sat_count;
   logic        clear_sat;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   fp8_quant_packer #(.E(4), .M(3), .LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .sat_count (sat_count),
      .clear_sat (clear_sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one beat, wait (bounded) for in_ready, return 2 time units after the accepting edge.
   task automatic beat(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("beat_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
      check({tag, "_vld"},  64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data),  64'(d));
      check({tag, "_keep"}, 64'(out_keep),  64'(k));
      check({tag, "_last"}, 64'(out_last),  64'(l));
   endtask

   initial begin
      int c0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      clear_sat = 1'b0;

      #12;
      check("rst_in_ready", 64'(in_ready),  64'd1);
      check("rst_out_vld",  64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data),  64'd0);
      check("rst_out_keep", 64'(out_keep),  64'd0);
      check("rst_out_last", 64'(out_last),  64'd0);
      check("rst_sat",      64'(sat_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // full word: 1.0, 2.0, -1.0, 0.5
      beat(32'h3F800000, 1'b0);
      beat(32'h40000000, 1'b0);
      beat(32'hBF800000, 1'b0);
      check("full_pre_vld", 64'(out_valid), 64'd0);
      beat(32'h3F000000, 1'b0);
      check_word("full", 32'h30B84038, 4'b1111, 1'b0);
      check("full_sat", 64'(sat_count), 64'd0);

      // partial word, then a single-element word lands in lane 0 (same-cycle drain + complete)
      beat(32'h3F800000, 1'b0);
      check("part_drain_vld", 64'(out_valid), 64'd0);
      beat(32'h40000000, 1'b1);
      check_word("part", 32'h00004038, 4'b0011, 1'b1);
      beat(32'h40000000, 1'b1);
      check_word("lane0", 32'h00000040, 4'b0001, 1'b1);

      // saturation
      beat(32'h447A0000, 1'b0);
      beat(32'hC47A0000, 1'b1);
      check_word("sat", 32'h0000FE7E, 4'b0011, 1'b1);
      check("sat_cnt2", 64'(sat_count), 64'd2);
      clear_sat = 1'b1;
      beat(32'h447A0000, 1'b1);
      clear_sat = 1'b0;
      check("sat_clear_pri", 64'(sat_count), 64'd0);
      check_word("sat_clr_word", 32'h0000007E, 4'b0001, 1'b1);

      // rounding: 1.0625 tie->even 0x38, 1.1875 tie->even 0x3A, 480 saturates, 2^-9 min subnormal
      beat(32'h3F880000, 1'b0);
      beat(32'h3F980000, 1'b0);
      beat(32'h43F00000, 1'b0);
      beat(32'h3B000000, 1'b0);
      check_word("round", 32'h017E3A38, 4'b1111, 1'b0);
      check("round_sat", 64'(sat_count), 64'd1);

      // drive the counter to its ceiling
      for (int i = 0; i < 65534; i++) beat(32'h447A0000, 1'b0);
      check("sat_ffff", 64'(sat_count), 64'hFFFF);
      beat(32'hC47A0000, 1'b0);
      check("sat_hold", 64'(sat_count), 64'hFFFF);
      beat(32'h3F800000, 1'b1);
      check_word("last_at_top", 32'h38FE7E7E, 4'b1111, 1'b1);
      check("sat_hold2", 64'(sat_count), 64'hFFFF);
      @(negedge clk);
      clear_sat = 1'b1;
      @(posedge clk);
      #2;
      clear_sat = 1'b0;
      check("sat_clear", 64'(sat_count), 64'd0);

      // backpressure
      beat(32'h3F800000, 1'b0);
      beat(32'h40000000, 1'b0);
      beat(32'hBF800000, 1'b0);
      out_ready = 1'b0;
      beat(32'h3F000000, 1'b0);
      check_word("bp", 32'h30B84038, 4'b1111, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'h40400000;
      in_last  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready),  64'd0);
         check("bp_vld",      64'(out_valid), 64'd1);
         check("bp_data",     64'(out_data),  64'h30B84038);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 64'(in_ready), 64'd1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      check("bp_drained", 64'(out_valid), 64'd0);
      beat(32'h40800000, 1'b0);
      beat(32'h3E800000, 1'b0);
      beat(32'h41000000, 1'b1);
      check_word("bp_resume", 32'h50284844, 4'b1111, 1'b1);

      // back-to-back: 8 beats at full rate
      c0 = cyc;
      beat(32'h3F800000, 1'b0);
      beat(32'h40000000, 1'b0);
      beat(32'h40800000, 1'b0);
      beat(32'h41000000, 1'b0);
      check_word("b2b_w1", 32'h50484038, 4'b1111, 1'b0);
      beat(32'h3F000000, 1'b0);
      check("b2b_gap_vld", 64'(out_valid), 64'd0);
      beat(32'h3E800000, 1'b0);
      beat(32'hC0000000, 1'b0);
      beat(32'hC0800000, 1'b0);
      check_word("b2b_w2", 32'hC8C02830, 4'b1111, 1'b0);
      check("b2b_cycles", 64'(cyc - c0), 64'd8);

      // reset mid-word
      beat(32'h447A0000, 1'b0);
      beat(32'h40000000, 1'b0);
      check("mid_sat", 64'(sat_count), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdy",  64'(in_ready),  64'd1);
      check("mid_rst_vld",  64'(out_valid), 64'd0);
      check("mid_rst_data", 64'(out_data),  64'd0);
      check("mid_rst_keep", 64'(out_keep),  64'd0);
      check("mid_rst_last", 64'(out_last),  64'd0);
      check("mid_rst_sat",  64'(sat_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      beat(32'h3F000000, 1'b0);
      beat(32'h3F800000, 1'b0);
      beat(32'h40000000, 1'b0);
      beat(32'h40800000, 1'b0);
      check_word("post_rst", 32'h48403830, 4'b1111, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
